// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Imported by the multiplier top level.
package seq_shift_add_mult_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Controller <-> multiplier bundle: operands and start in,
// product and status out.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 4
);

  logic               START;
  logic               SIGNED;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] P;
  logic               BUSY;
  logic               READY;
  logic               DONE;

  modport master (
    output START, SIGNED, A, B,
    input  P, BUSY, READY, DONE
  );

  modport slave (
    input  START, SIGNED, A, B,
    output P, BUSY, READY, DONE
  );

endinterface

// File: rtl/seq_shift_add_mult_addsub_step.sv
// One shift-and-add iteration: WIDTH+1 add/sub of the accumulator
// high half, returning the right-shifted high half and the bit shifted out.
module mult_addsub_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] a,
  input  logic             b0,
  input  logic             sgn,
  input  logic             sub,
  output logic [WIDTH-1:0] acc_nxt,
  output logic             lsb
);

  logic [WIDTH:0] acc_x;
  logic [WIDTH:0] a_x;
  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  // sum[WIDTH] is the carry (unsigned) or the true sign (signed)
  always_comb begin
    acc_x   = {sgn & acc_hi[WIDTH-1], acc_hi};
    a_x     = {sgn & a[WIDTH-1], a};
    addend  = b0 ? a_x : '0;
    sum     = sub ? (acc_x - addend) : (acc_x + addend);
    acc_nxt = sum[WIDTH:1];
    lsb     = sum[0];
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier, one partial
// product per clock, unsigned or two's-complement operands.
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic CK,
  input logic RST,
  seq_shift_add_mult_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_nxt;
  logic               sgn_r;
  logic               lsb;
  logic               last;
  logic               done_r;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] p_r;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // MSB of B carries negative weight in signed mode
  mult_addsub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_hi  (acc_hi),
    .a       (a_r),
    .b0      (b_sh[0]),
    .sgn     (sgn_r),
    .sub     (sgn_r & last),
    .acc_nxt (acc_nxt),
    .lsb     (lsb)
  );

  always_ff @(posedge CK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.START)
      state_nxt = ST_RUN;
    else if (state == ST_RUN && last)
      state_nxt = ST_IDLE;
  end

  always_comb begin
    bus.BUSY  = (state == ST_RUN);
    bus.READY = (state == ST_IDLE);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      a_r    <= '0;
      b_sh   <= '0;
      acc_hi <= '0;
      sgn_r  <= 1'b0;
      cnt    <= '0;
      p_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.START) begin
        a_r    <= bus.A;
        b_sh   <= bus.B;
        sgn_r  <= bus.SIGNED;
        acc_hi <= '0;
        cnt    <= '0;
      end else if (state == ST_RUN) begin
        acc_hi <= acc_nxt;
        b_sh   <= {lsb, b_sh[WIDTH-1:1]};
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          p_r    <= {acc_nxt, lsb, b_sh[WIDTH-1:1]};
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.P    = p_r;
  assign bus.DONE = done_r;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult at WIDTH=4 and WIDTH=8.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult_if #(.WIDTH(4)) m4 ();
  seq_shift_add_mult_if #(.WIDTH(8)) m8 ();

  seq_shift_add_mult #(.WIDTH(4)) u4 (
    .CK  (clk),
    .RST (rst),
    .bus (m4)
  );

  seq_shift_add_mult #(.WIDTH(8)) u8 (
    .CK  (clk),
    .RST (rst),
    .bus (m8)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go4(input logic [3:0] a,
                     input logic [3:0] b,
                     input logic s);
    @(negedge clk);
    m4.START  = 1'b1;
    m4.A      = a;
    m4.B      = b;
    m4.SIGNED = s;
    @(negedge clk);
    m4.START  = 1'b0;
    m4.A      = ~a;
    m4.B      = ~b;
    m4.SIGNED = ~s;
  endtask

  task automatic fin4(input string tag,
                      input logic [7:0] exp,
                      input bit tail);
    logic [7:0] prev;
    prev = m4.P;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".busy"}, 16'(m4.BUSY), 16'd1);
      chk({tag, ".hold"}, 16'(m4.P), 16'(prev));
      chk({tag, ".nodone"}, 16'(m4.DONE), 16'd0);
      @(negedge clk);
    end
    chk({tag, ".done"}, 16'(m4.DONE), 16'd1);
    chk({tag, ".ready"}, 16'(m4.READY), 16'd1);
    chk({tag, ".idle"}, 16'(m4.BUSY), 16'd0);
    chk({tag, ".p"}, 16'(m4.P), 16'(exp));
    if (tail) begin
      @(negedge clk);
      chk({tag, ".pulse"}, 16'(m4.DONE), 16'd0);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic s);
    int sa;
    int sb;
    sa = s ? int'($signed(a)) : int'({24'd0, a});
    sb = s ? int'($signed(b)) : int'({24'd0, b});
    return 16'(sa * sb);
  endfunction

  task automatic t8(input string tag,
                    input logic [7:0] a,
                    input logic [7:0] b,
                    input logic s,
                    input logic [15:0] exp);
    @(negedge clk);
    m8.START  = 1'b1;
    m8.A      = a;
    m8.B      = b;
    m8.SIGNED = s;
    @(negedge clk);
    m8.START  = 1'b0;
    m8.A      = 8'h5A;
    m8.B      = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      chk({tag, ".busy"}, 16'(m8.BUSY), 16'd1);
      @(negedge clk);
    end
    chk({tag, ".done"}, 16'(m8.DONE), 16'd1);
    chk({tag, ".p"}, m8.P, exp);
  endtask

  initial begin
    rst       = 1'b1;
    m4.START  = 1'b0;
    m4.SIGNED = 1'b0;
    m4.A      = '0;
    m4.B      = '0;
    m8.START  = 1'b0;
    m8.SIGNED = 1'b0;
    m8.A      = '0;
    m8.B      = '0;

    #12;
    chk("rst.p4", 16'(m4.P), 16'd0);
    chk("rst.ready", 16'(m4.READY), 16'd1);
    chk("rst.busy", 16'(m4.BUSY), 16'd0);
    chk("rst.done", 16'(m4.DONE), 16'd0);
    chk("rst.p8", m8.P, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    go4(4'd15, 4'd15, 1'b0);
    fin4("u15x15", 8'hE1, 1'b1);
    go4(4'h8, 4'h8, 1'b1);
    fin4("sm8xm8", 8'h40, 1'b1);
    go4(4'h8, 4'h7, 1'b1);
    fin4("sm8x7", 8'hC8, 1'b1);
    go4(4'h7, 4'hF, 1'b1);
    fin4("s7xm1", 8'hF9, 1'b1);
    go4(4'd0, 4'd9, 1'b0);
    fin4("u0x9", 8'h00, 1'b1);
    go4(4'd11, 4'd3, 1'b0);
    fin4("u11x3", 8'h21, 1'b1);
    go4(4'd0, 4'hD, 1'b1);
    fin4("s0xm3", 8'h00, 1'b1);
    go4(4'h9, 4'h3, 1'b1);
    fin4("sm7x3", 8'hEB, 1'b1);
    go4(4'd6, 4'd0, 1'b0);
    fin4("u6x0", 8'h00, 1'b1);

    go4(4'd3, 4'd5, 1'b0);
    go4(4'd2, 4'd6, 1'b0);
    fin4("abort", 8'd12, 1'b1);

    go4(4'd3, 4'd4, 1'b0);
    fin4("chain1", 8'd12, 1'b0);
    m4.START  = 1'b1;
    m4.A      = 4'd5;
    m4.B      = 4'd5;
    m4.SIGNED = 1'b0;
    @(negedge clk);
    m4.START  = 1'b0;
    fin4("chain2", 8'd25, 1'b1);

    go4(4'd15, 4'd15, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst.p", 16'(m4.P), 16'd0);
    chk("mrst.ready", 16'(m4.READY), 16'd1);
    chk("mrst.busy", 16'(m4.BUSY), 16'd0);
    chk("mrst.done", 16'(m4.DONE), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.stay", 16'(m4.READY), 16'd1);

    t8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    t8("sm128sq", 8'h80, 8'h80, 1'b1, 16'h4000);
    t8("sm1x127", 8'hFF, 8'h7F, 1'b1, 16'hFF81);
    t8("u200x3", 8'd200, 8'd3, 1'b0, 16'd600);
    for (int k = 0; k < 24; k++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'(k % 2);
      t8("rand8", ra, rb, rs, ref8(ra, rb, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
